// File: rtl/par2serial_phy_tx.sv
`default_nettype none
// ============================================================================
// Module   : par2serial_phy_tx
// Brief    : Byte-to-serial transmitter with a one-entry holding register.
//            Sends IDLE_BYTE frames when no byte is waiting at a frame edge.
// Revision : 1.0 - initial release
// ============================================================================
module par2serial_phy_tx #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     IDLE_BYTE = 8'hBC,
    parameter int unsigned          CNT_W     = 3
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             frame_start,
    output logic             sending_data,
    output logic [7:0]       bytes_sent
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic             r_df;
    logic [7:0]       r_bytes_sent;

    logic             w_wrap;
    logic             w_accept;

    assign w_wrap   = (r_cnt == c_cnt_last);
    // The holding slot frees up on the wrap edge, so it may refill on that same edge.
    assign ready_out = !r_hold_full || w_wrap;
    assign w_accept  = valid_in && ready_out;

    assign data_out     = r_sh[WIDTH-1];
    assign frame_start  = (r_cnt == '0);
    assign sending_data = r_df;
    assign bytes_sent   = r_bytes_sent;

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt        <= '0;
            r_sh         <= IDLE_BYTE;
            r_df         <= 1'b0;
            r_bytes_sent <= 8'd0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            if (r_hold_full) begin
                r_sh         <= r_hold;
                r_df         <= 1'b1;
                r_bytes_sent <= r_bytes_sent + 8'd1;
            end else begin
                r_sh <= IDLE_BYTE;
                r_df <= 1'b0;
            end
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
        end
    end

    // A byte arriving on the wrap edge always lands in hold; it never bypasses into the shifter.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
        end else if (w_wrap) begin
            r_hold_full <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_par2serial_phy_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_par2serial_phy_tx
// Brief    : Directed self-checking bench for par2serial_phy_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_par2serial_phy_tx;

    logic       clk_32f;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       frame_start;
    logic       sending_data;
    logic [7:0] bytes_sent;

    int checks = 0;
    int errors = 0;
    logic [7:0] txq[$];

    par2serial_phy_tx #(
        .WIDTH    (8),
        .IDLE_BYTE(8'hBC),
        .CNT_W    (3)
    ) dut (
        .clk_32f     (clk_32f),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .frame_start (frame_start),
        .sending_data(sending_data),
        .bytes_sent  (bytes_sent)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; if the current byte is taken, present the next queued one.
    task automatic tick();
        logic acc;
        acc = valid_in && ready_out;
        @(posedge clk_32f);
        #1;
        if (acc) begin
            if (txq.size() > 0) begin
                data_in = txq.pop_front();
            end else begin
                valid_in = 1'b0;
                data_in  = 8'hxx;
            end
        end
    endtask

    // Entered at the first bit of a frame; leaves at the first bit of the next.
    task automatic check_frame(input string tag, input logic [7:0] exp_byte, input logic exp_df);
        for (int b = 0; b < 8; b++) begin
            chk({tag, "_bit"}, {31'd0, data_out}, {31'd0, exp_byte[7-b]});
            chk({tag, "_fs"}, {31'd0, frame_start}, {31'd0, (b == 0)});
            chk({tag, "_df"}, {31'd0, sending_data}, {31'd0, exp_df});
            tick();
        end
    endtask

    task automatic do_reset(input string tag);
        reset_L = 1'b0;
        #2;
        chk({tag, "_rst_dout"}, {31'd0, data_out}, 32'd1);
        chk({tag, "_rst_fs"}, {31'd0, frame_start}, 32'd1);
        chk({tag, "_rst_rdy"}, {31'd0, ready_out}, 32'd1);
        chk({tag, "_rst_df"}, {31'd0, sending_data}, 32'd0);
        chk({tag, "_rst_cnt"}, {24'd0, bytes_sent}, 32'd0);
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'hxx;
        repeat (2) @(posedge clk_32f);
        #1;

        // 1: idle line after reset
        do_reset("t1");
        for (int f = 0; f < 4; f++) check_frame("t1_idle", 8'hBC, 1'b0);
        chk("t1_bytes", {24'd0, bytes_sent}, 32'd0);

        // 2: single byte accepted at cnt=2
        tick();
        tick();
        data_in  = 8'hA5;
        valid_in = 1'b1;
        chk("t2_rdy_cnt2", {31'd0, ready_out}, 32'd1);
        tick();
        for (int k = 3; k < 7; k++) begin
            chk("t2_rdy_busy", {31'd0, ready_out}, 32'd0);
            tick();
        end
        chk("t2_rdy_cnt7", {31'd0, ready_out}, 32'd1);
        tick();
        chk("t2_bytes", {24'd0, bytes_sent}, 32'd1);
        check_frame("t2_data", 8'hA5, 1'b1);
        check_frame("t2_after", 8'hBC, 1'b0);

        // 3: back-to-back stream
        do_reset("t3");
        data_in  = 8'h01;
        valid_in = 1'b1;
        txq      = '{8'h80, 8'hFF};
        check_frame("t3_idle", 8'hBC, 1'b0);
        check_frame("t3_b0", 8'h01, 1'b1);
        check_frame("t3_b1", 8'h80, 1'b1);
        chk("t3_bytes", {24'd0, bytes_sent}, 32'd3);
        check_frame("t3_b2", 8'hFF, 1'b1);
        check_frame("t3_tail", 8'hBC, 1'b0);

        // 4: accept on wrap edge with hold empty
        repeat (7) tick();
        data_in  = 8'h3C;
        valid_in = 1'b1;
        chk("t4_rdy_wrap", {31'd0, ready_out}, 32'd1);
        tick();
        check_frame("t4_idle", 8'hBC, 1'b0);
        check_frame("t4_data", 8'h3C, 1'b1);
        chk("t4_bytes", {24'd0, bytes_sent}, 32'd4);

        // 5: reset mid-frame with a byte held
        data_in  = 8'h55;
        valid_in = 1'b1;
        tick();
        repeat (3) tick();
        chk("t5_rdy_held", {31'd0, ready_out}, 32'd0);
        do_reset("t5");
        check_frame("t5_idle0", 8'hBC, 1'b0);
        check_frame("t5_idle1", 8'hBC, 1'b0);
        chk("t5_bytes", {24'd0, bytes_sent}, 32'd0);

        // 6: bytes_sent wrap over 257 data frames
        data_in  = 8'h00;
        valid_in = 1'b1;
        txq.delete();
        for (int i = 1; i < 257; i++) txq.push_back(8'(i));
        check_frame("t6_idle", 8'hBC, 1'b0);
        for (int n = 1; n <= 257; n++) begin
            logic [7:0] nb;
            nb = 8'(n);
            chk("t6_bytes", {24'd0, bytes_sent}, {24'd0, nb});
            check_frame("t6_data", 8'(n - 1), 1'b1);
        end
        check_frame("t6_tail", 8'hBC, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/par2serial_phy_tx.md
Name: par2serial_phy_tx

Overview:
- Transmit-side serializer that sits directly downstream of the 4:1 byte multiplexer.
- Takes the mux's 8-bit output byte and its valid flag, and shifts bytes out one bit per clock on a single serial line.
- When no valid byte is ready at a frame boundary, it sends the IDLE/comma byte 0xBC so the link never stalls.
- Uses a one-entry holding register with a valid/ready handshake to decouple the mux cadence from the frame cadence.

Parameters:
- WIDTH, 8, byte width; also the number of bits per serial frame.
- IDLE_BYTE, 8'hBC, pattern sent in frames that carry no data.
- CNT_W, 3, bit-counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk_32f  input  1  serial bit clock; all state changes on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  byte from the upstream mux (dataout of the mux stage).
- valid_in  input  1  data_in is valid; upstream holds data_in and valid_in stable until accepted.
- ready_out  output  1  the holding register can accept data_in this cycle.
- data_out  output  1  serial bit, MSB of each frame first.
- frame_start  output  1  high during the first bit of each frame.
- sending_data  output  1  high for the whole frame when that frame carries a data byte; low for IDLE frames.
- bytes_sent  output  8  count of data frames started; wraps 255 -> 0; IDLE frames are not counted.

Behaviour:
- Clock and reset: one clock, clk_32f. reset_L is asynchronous and active-low.
- State: bit counter cnt (0..WIDTH-1), shift register sh, holding register hold with hold_full flag, data-frame flag df, bytes_sent.
- Reset (reset_L=0, asynchronous, any time including mid-frame):
  - cnt=0, sh=IDLE_BYTE, hold_full=0, df=0, bytes_sent=0.
  - Outputs therefore: data_out=1 (MSB of 0xBC), frame_start=1, sending_data=0, ready_out=1.
  - Any held or partially sent byte is discarded.
  - The first frame after reset release is always IDLE.
- Outputs are combinational from registers:
  - data_out = sh[WIDTH-1]
  - frame_start = (cnt==0)
  - sending_data = df
  - ready_out = !hold_full || (cnt==WIDTH-1)
- Accept: a transfer occurs on an edge where valid_in && ready_out. data_in is written to hold and hold_full is set.
- Every edge with cnt != WIDTH-1: cnt++, and sh shifts left by one with a 0 shifted in.
- Wrap edge (cnt==WIDTH-1): cnt goes to 0, then:
  - If hold_full: sh loads hold, df=1, bytes_sent++, hold_full clears.
  - Otherwise: sh loads IDLE_BYTE, df=0.
- Simultaneous accept on the wrap edge: the new byte goes into hold and hold_full=1. There is no bypass into sh:
  - If hold was full, the old hold content goes to sh and the new byte waits one frame.
  - If hold was empty, this frame is IDLE and the new byte is sent in the following frame.
- Latency: a byte accepted on an edge at cnt=k (k<WIDTH-1, hold empty) drives its first bit on data_out after the edge WIDTH-1-k cycles later.
- Throughput: with valid_in held continuously, one data frame per WIDTH cycles and no IDLE frames between bytes.
- Back-pressure: while hold_full and cnt!=WIDTH-1, ready_out=0. Upstream must hold its byte; no byte is dropped or duplicated.
- Data bytes equal to IDLE_BYTE are sent unchanged; sending_data is the only way to tell them apart from IDLE.
- X on data_in while valid_in=0 never propagates to data_out.

Test Plan:
1. Reset, then valid_in=0 for 32 cycles -> data_out repeats 1,0,1,1,1,1,0,0 four times; frame_start high on cycles 0, 8, 16, 24; sending_data=0; bytes_sent=0.
2. Single byte: data_in=0xA5 with valid_in for one accepted edge at cnt=2 -> ready_out drops until cnt=7; the next frame shows 1,0,1,0,0,1,0,1 with sending_data=1; bytes_sent=1; the following frame is IDLE.
3. Back-to-back stream 0x01, 0x80, 0xFF with valid_in held (advance only on accepted edges) -> three consecutive data frames 00000001, 10000000, 11111111; no IDLE frame between them; bytes_sent=3.
4. Accept on the wrap edge with hold empty (0x3C at cnt=7) -> the next frame is IDLE (0xBC); the frame after it is 00111100 with sending_data=1.
5. Reset mid-operation: hold_full with 0x55 and sh mid-frame at cnt=4, pulse reset_L low between clock edges -> immediately data_out=1, frame_start=1, ready_out=1; after release one IDLE frame follows; 0x55 is never transmitted; bytes_sent=0.
6. Wrap test: 256 consecutive data frames -> bytes_sent returns to 0; the 257th data frame gives bytes_sent=1.
